gtxe2_chnl_rx_linkctl: RTL and testbench

Link-bring-up controller for the GTXE2 receive channel. It sequences comma alignment and settle, then supervises the locked link. It sits beside the RX channel on the RXUSRCLK2 domain: it consumes the RX status outputs (electrical idle, alignment, per-byte decode errors) and drives the alignment-enable and polarity controls back into the channel. It optionally searches receive polarity automatically when alignment cannot be achieved.

---
 rtl/gtxe2_chnl_rx_linkctl_if.sv | 25 ++
 rtl/gtxe2_chnl_rx_linkctl.sv | 184 ++++++++++++++++++
 tb/tb_gtxe2_chnl_rx_linkctl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gtxe2_chnl_rx_linkctl_if.sv
// RX channel status/control bundle between the GTXE2 RX channel and its link controller.
// master = controller side, slave = channel side.
interface gtxe2_chnl_rx_linkctl_if #(
   parameter int ISK_WIDTH = 2
);
   logic                 rxelecidle;
   logic                 rxbyteisaligned;
   logic                 rxbyterealign;
   logic [ISK_WIDTH-1:0] rxnotintable;
   logic [ISK_WIDTH-1:0] rxdisperr;
   logic                 rxpcommaalignen;
   logic                 rxmcommaalignen;
   logic                 rxcommadeten;
   logic                 rxpolarity;

   modport master (
      input  rxelecidle, rxbyteisaligned, rxbyterealign, rxnotintable, rxdisperr,
      output rxpcommaalignen, rxmcommaalignen, rxcommadeten, rxpolarity
   );

   modport slave (
      output rxelecidle, rxbyteisaligned, rxbyterealign, rxnotintable, rxdisperr,
      input  rxpcommaalignen, rxmcommaalignen, rxcommadeten, rxpolarity
   );
endinterface

// File: rtl/gtxe2_chnl_rx_linkctl.sv
// GTXE2 RX link bring-up controller: idle filter, comma alignment, settle, locked error supervision.
// Define GTXE2_RX_AUTOPOL_EN to toggle rxpolarity on every ALIGN timeout instead of dropping to IDLE.
module gtxe2_chnl_rx_linkctl #(
   parameter int   ISK_WIDTH     = 2,
   parameter int   IDLE_FILTER   = 16,
   parameter int   ALIGN_TIMEOUT = 1024,
   parameter int   SETTLE_CYCLES = 8,
   parameter int   ERR_WINDOW    = 256,
   parameter int   ERR_THRESH    = 4,
   parameter logic INIT_POLARITY = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   gtxe2_chnl_rx_linkctl_if.master       rx,
   output logic                          link_up,
   output logic [2:0]                    state,
   output logic [7:0]                    realign_cnt
);
   localparam int IDLE_W   = $clog2(IDLE_FILTER + 1);
   localparam int ALIGN_W  = $clog2(ALIGN_TIMEOUT + 1);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int WIN_W    = $clog2(ERR_WINDOW + 1);
   localparam int ACC_W    = $clog2(ERR_THRESH + 1);
   localparam int SUM_W    = 16;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_IDLE   = 3'd1,
      ST_ALIGN  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_LOCKED = 3'd4
   } state_t;

   state_t                state_reg, state_next;
   logic [IDLE_W-1:0]     idle_cnt_reg, idle_cnt_next;
   logic [ALIGN_W-1:0]    align_tmr_reg, align_tmr_next;
   logic [SETTLE_W-1:0]   settle_cnt_reg, settle_cnt_next;
   logic [WIN_W-1:0]      win_cnt_reg, win_cnt_next;
   logic [ACC_W-1:0]      err_acc_reg, err_acc_next;
   logic [7:0]            realign_cnt_reg, realign_cnt_next;
`ifdef GTXE2_RX_AUTOPOL_EN
   logic                  pol_reg, pol_next;
`endif

   // Case-equality against 1 so X/Z on channel status reads as deasserted.
   logic en_i, idle_i, aligned_i, realign_i;
   assign en_i      = (enable             === 1'b1);
   assign idle_i    = (rx.rxelecidle      === 1'b1);
   assign aligned_i = (rx.rxbyteisaligned === 1'b1);
   assign realign_i = (rx.rxbyterealign   === 1'b1);

   logic [ISK_WIDTH-1:0] err_bit;
   generate
      for (genvar gi = 0; gi < ISK_WIDTH; gi++) begin : g_err
         assign err_bit[gi] = (rx.rxnotintable[gi] === 1'b1) || (rx.rxdisperr[gi] === 1'b1);
      end
   endgenerate

   logic [SUM_W-1:0] err_cnt, err_sum;
   logic [ACC_W-1:0] acc_sat;
   always_comb begin
      err_cnt = '0;
      for (int i = 0; i < ISK_WIDTH; i++) begin
         err_cnt = err_cnt + SUM_W'(err_bit[i]);
      end
      err_sum = SUM_W'(err_acc_reg) + err_cnt;
      acc_sat = (err_sum >= SUM_W'(ERR_THRESH)) ? ACC_W'(ERR_THRESH) : ACC_W'(err_sum);
   end

   always_comb begin
      state_next       = state_reg;
      idle_cnt_next    = idle_cnt_reg;
      align_tmr_next   = align_tmr_reg;
      settle_cnt_next  = settle_cnt_reg;
      win_cnt_next     = win_cnt_reg;
      err_acc_next     = err_acc_reg;
      realign_cnt_next = realign_cnt_reg;
`ifdef GTXE2_RX_AUTOPOL_EN
      pol_next         = pol_reg;
`endif
      if (!en_i) begin
         state_next = ST_OFF;
      end else if (idle_i && (state_reg inside {ST_IDLE, ST_ALIGN, ST_SETTLE, ST_LOCKED})) begin
         state_next    = ST_IDLE;
         idle_cnt_next = '0;
      end else begin
         case (state_reg)
            ST_OFF: state_next = ST_IDLE;
            ST_IDLE: begin
               if (idle_cnt_reg == IDLE_W'(IDLE_FILTER - 1)) state_next = ST_ALIGN;
               else idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
            end
            ST_ALIGN: begin
               if (aligned_i) begin
                  state_next = ST_SETTLE;
               end else if (align_tmr_reg == ALIGN_W'(ALIGN_TIMEOUT - 1)) begin
`ifdef GTXE2_RX_AUTOPOL_EN
                  pol_next       = ~pol_reg;
                  align_tmr_next = '0;
`else
                  state_next     = ST_IDLE;
`endif
               end else begin
                  align_tmr_next = align_tmr_reg + ALIGN_W'(1);
               end
            end
            ST_SETTLE: begin
               if (!aligned_i) state_next = ST_ALIGN;
               else if (settle_cnt_reg == SETTLE_W'(SETTLE_CYCLES - 1)) state_next = ST_LOCKED;
               else settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
            end
            ST_LOCKED: begin
               // Threshold is judged only at window end, including that cycle's errors.
               if (realign_i) begin
                  state_next = ST_ALIGN;
               end else if (win_cnt_reg == WIN_W'(ERR_WINDOW - 1)) begin
                  if (err_sum >= SUM_W'(ERR_THRESH)) state_next = ST_ALIGN;
                  else begin
                     win_cnt_next = '0;
                     err_acc_next = '0;
                  end
               end else begin
                  win_cnt_next = win_cnt_reg + WIN_W'(1);
                  err_acc_next = acc_sat;
               end
            end
            default: state_next = ST_OFF;
         endcase
      end

      // Every counter starts from zero in a newly entered state.
      if (state_next != state_reg) begin
         idle_cnt_next   = '0;
         align_tmr_next  = '0;
         settle_cnt_next = '0;
         win_cnt_next    = '0;
         err_acc_next    = '0;
      end
      if (state_reg == ST_LOCKED && state_next == ST_ALIGN && realign_cnt_reg != 8'hFF)
         realign_cnt_next = realign_cnt_reg + 8'd1;
`ifdef GTXE2_RX_AUTOPOL_EN
      if (state_next == ST_OFF) pol_next = INIT_POLARITY;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_OFF;
         idle_cnt_reg    <= '0;
         align_tmr_reg   <= '0;
         settle_cnt_reg  <= '0;
         win_cnt_reg     <= '0;
         err_acc_reg     <= '0;
         realign_cnt_reg <= '0;
`ifdef GTXE2_RX_AUTOPOL_EN
         pol_reg         <= INIT_POLARITY;
`endif
      end else begin
         state_reg       <= state_next;
         idle_cnt_reg    <= idle_cnt_next;
         align_tmr_reg   <= align_tmr_next;
         settle_cnt_reg  <= settle_cnt_next;
         win_cnt_reg     <= win_cnt_next;
         err_acc_reg     <= err_acc_next;
         realign_cnt_reg <= realign_cnt_next;
`ifdef GTXE2_RX_AUTOPOL_EN
         pol_reg         <= pol_next;
`endif
      end
   end

`ifdef GTXE2_RX_AUTOPOL_EN
   assign rx.rxpolarity = pol_reg;
`else
   assign rx.rxpolarity = INIT_POLARITY;
`endif
   assign rx.rxcommadeten    = (state_reg == ST_ALIGN) || (state_reg == ST_SETTLE) || (state_reg == ST_LOCKED);
   assign rx.rxpcommaalignen = (state_reg == ST_ALIGN);
   assign rx.rxmcommaalignen = (state_reg == ST_ALIGN);
   assign link_up            = (state_reg == ST_LOCKED);
   assign state              = state_reg;
   assign realign_cnt        = realign_cnt_reg;
endmodule

// File: tb/tb_gtxe2_chnl_rx_linkctl.sv
// Directed bench for gtxe2_chnl_rx_linkctl: expected outputs queued per step, compared after each edge.
// Covers both builds of GTXE2_RX_AUTOPOL_EN.
module tb_gtxe2_chnl_rx_linkctl;
   localparam int ISK_WIDTH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       link_up;
   logic [2:0] state;
   logic [7:0] realign_cnt;

   gtxe2_chnl_rx_linkctl_if #(.ISK_WIDTH(ISK_WIDTH)) bus ();

   gtxe2_chnl_rx_linkctl #(
      .ISK_WIDTH(ISK_WIDTH), .IDLE_FILTER(16), .ALIGN_TIMEOUT(32), .SETTLE_CYCLES(8),
      .ERR_WINDOW(16), .ERR_THRESH(4), .INIT_POLARITY(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rx(bus),
      .link_up(link_up), .state(state), .realign_cnt(realign_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic       pol;
      logic [7:0] rc;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   logic       pol_e = 1'b0;
   logic [7:0] rc_e = 8'd0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Moore outputs are derived from the expected state using the output table.
   task automatic compare_head();
      exp_t e;
      e = sb.pop_front();
      $display("%0t %s state=%0d link_up=%0b pol=%0b realign_cnt=%0d", $time, e.tag, state, link_up,
               bus.rxpolarity, realign_cnt);
      chk({e.tag, ".state"},   {5'd0, state},              {5'd0, e.st});
      chk({e.tag, ".link_up"}, {7'd0, link_up},            {7'd0, e.st == 3'd4});
      chk({e.tag, ".commadet"},{7'd0, bus.rxcommadeten},   {7'd0, e.st inside {3'd2, 3'd3, 3'd4}});
      chk({e.tag, ".pcomma"},  {7'd0, bus.rxpcommaalignen},{7'd0, e.st == 3'd2});
      chk({e.tag, ".mcomma"},  {7'd0, bus.rxmcommaalignen},{7'd0, e.st == 3'd2});
      chk({e.tag, ".pol"},     {7'd0, bus.rxpolarity},     {7'd0, e.pol});
      chk({e.tag, ".realign"}, realign_cnt,                e.rc);
   endtask

   task automatic push_exp(input string tag, input logic [2:0] st);
      exp_t e;
      e.tag = tag;
      e.st  = st;
      e.pol = pol_e;
      e.rc  = rc_e;
      sb.push_back(e);
   endtask

   task automatic check_now(input string tag, input logic [2:0] st);
      push_exp(tag, st);
      compare_head();
   endtask

   task automatic step(input string tag, input logic [2:0] st);
      push_exp(tag, st);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   task automatic steps(input int n, input string tag, input logic [2:0] st);
      for (int i = 0; i < n; i++) step(tag, st);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.rxelecidle      = 1'b0;
      bus.rxbyteisaligned = 1'b0;
      bus.rxbyterealign   = 1'b0;
      bus.rxnotintable    = '0;
      bus.rxdisperr       = '0;
      #2;
      check_now("reset", 3'd0);
      steps(2, "reset_hold", 3'd0);

      // Bring-up: 16 IDLE, 3 ALIGN, 8 SETTLE, LOCKED.
      rst_n = 1'b1;
      enable = 1'b1;
      step("off_to_idle", 3'd1);
      steps(15, "idle_filter", 3'd1);
      step("idle_to_align", 3'd2);
      steps(2, "align_wait", 3'd2);
      bus.rxbyteisaligned = 1'b1;
      step("align_to_settle", 3'd3);
      steps(7, "settle", 3'd3);
      step("settle_to_locked", 3'd4);

      // Three single-bit errors in one window: stay LOCKED across the window end.
      bus.rxnotintable = 2'b01; bus.rxdisperr = 2'b00;
      step("win1_nit", 3'd4);
      bus.rxnotintable = 2'b00; bus.rxdisperr = 2'b10;
      step("win1_disp", 3'd4);
      bus.rxnotintable = 2'b01; bus.rxdisperr = 2'b01;
      step("win1_both_same_byte", 3'd4);
      bus.rxnotintable = 2'b00; bus.rxdisperr = 2'b00;
      steps(12, "win1", 3'd4);
      step("win1_end_stay", 3'd4);

      // Two double-byte errors: realign at window end only.
      bus.rxnotintable = 2'b11;
      steps(2, "win2_err", 3'd4);
      bus.rxnotintable = 2'b00;
      steps(13, "win2", 3'd4);
      rc_e = 8'd1;
      step("win2_end_realign", 3'd2);
      step("realign_to_settle", 3'd3);
      steps(7, "settle", 3'd3);
      step("relock", 3'd4);

      // rxbyterealign exits LOCKED immediately.
      bus.rxbyterealign = 1'b1;
      rc_e = 8'd2;
      step("byterealign", 3'd2);
      bus.rxbyterealign = 1'b0;
      step("to_settle", 3'd3);
      steps(7, "settle", 3'd3);
      step("relock2", 3'd4);

      // Electrical idle in LOCKED, then a glitch restarts the idle filter.
      bus.rxelecidle = 1'b1;
      step("elecidle_locked", 3'd1);
      bus.rxelecidle = 1'b0;
      steps(5, "idle_partial", 3'd1);
      bus.rxelecidle = 1'b1;
      step("idle_glitch", 3'd1);
      bus.rxelecidle = 1'b0;
      steps(15, "idle_refilter", 3'd1);
      step("idle_to_align", 3'd2);
      step("to_settle", 3'd3);
      steps(7, "settle", 3'd3);
      step("relock3", 3'd4);

      // enable=0 outranks rxbyterealign; no realign is counted.
      enable = 1'b0;
      bus.rxbyterealign = 1'b1;
      step("disable_over_realign", 3'd0);
      bus.rxbyterealign = 1'b0;
      enable = 1'b1;
      step("reenable", 3'd1);

      // ALIGN timeout handling.
      bus.rxbyteisaligned = 1'b0;
      steps(15, "idle_filter", 3'd1);
      step("idle_to_align", 3'd2);
      steps(31, "align_timeout_wait", 3'd2);
`ifdef GTXE2_RX_AUTOPOL_EN
      pol_e = 1'b1;
      step("pol_toggle1", 3'd2);
      steps(31, "align_pol1", 3'd2);
      pol_e = 1'b0;
      step("pol_toggle2", 3'd2);
      bus.rxbyteisaligned = 1'b1;
      step("to_settle", 3'd3);
      steps(7, "settle", 3'd3);
      step("lock_after_search", 3'd4);
      bus.rxbyterealign = 1'b1;
      bus.rxbyteisaligned = 1'b0;
      rc_e = 8'd3;
      step("realign_for_tie", 3'd2);
      bus.rxbyterealign = 1'b0;
`else
      step("timeout_to_idle", 3'd1);
      steps(15, "idle_filter", 3'd1);
      step("idle_to_align", 3'd2);
`endif
      // Alignment on the timeout cycle wins.
      steps(31, "align_tie_wait", 3'd2);
      bus.rxbyteisaligned = 1'b1;
      step("align_wins_tie", 3'd3);
      bus.rxbyteisaligned = 1'b0;
      step("settle_drop", 3'd2);
      steps(31, "align_timeout_wait2", 3'd2);
`ifdef GTXE2_RX_AUTOPOL_EN
      pol_e = 1'b1;
      step("pol_toggle3", 3'd2);
`else
      step("timeout_to_idle2", 3'd1);
      steps(15, "idle_filter", 3'd1);
      step("idle_to_align", 3'd2);
`endif
      steps(3, "align_mid", 3'd2);

      // Asynchronous reset between edges.
      #3;
      rst_n = 1'b0;
      #1;
      pol_e = 1'b0;
      rc_e = 8'd0;
      check_now("async_reset", 3'd0);
      step("reset_held", 3'd0);
      rst_n = 1'b1;
      step("post_reset_idle", 3'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
